// File: rtl/riscv_pkg.sv
// Shared decode constants for the load/store unit: mem_op encodings,
// LSU state enum and small op-classification helpers.
package riscv_pkg;

    localparam logic [3:0] MEM_NONE = 4'b0000;
    localparam logic [3:0] MEM_LB   = 4'b0001;
    localparam logic [3:0] MEM_LH   = 4'b0010;
    localparam logic [3:0] MEM_LW   = 4'b0011;
    localparam logic [3:0] MEM_LBU  = 4'b0100;
    localparam logic [3:0] MEM_LHU  = 4'b0110;
    localparam logic [3:0] MEM_SB   = 4'b1001;
    localparam logic [3:0] MEM_SH   = 4'b1010;
    localparam logic [3:0] MEM_SW   = 4'b1111;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] sz;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: sz = SIZE_B;
            MEM_LH, MEM_LHU, MEM_SH: sz = SIZE_H;
            default:                 sz = SIZE_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/half lane addressed by off from the
// captured bus word and sign- or zero-extends it according to the load op.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (off)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];

        case (op)
            MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: result = {24'h000000, byte_sel};
            MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: result = {16'h0000, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer (IDLE/REQ/WAIT/DONE) driving a
// req/gnt/rvalid data bus. Build with LSU_TIMEOUT_EN to add a REQ+WAIT watchdog.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata_out,
    output logic              done,
    output logic              misalign_err,
    output logic              access_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err,
    output logic [1:0]        dbg_state
);

    // Handshake: bus_req is the valid and bus_gnt the ready; the request is
    // accepted in a cycle where both are high, and bus_we/addr/be/wdata hold
    // steady while bus_req waits. bus_rvalid is only honoured in WAIT.

    lsu_state_t        state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rword_q;
    logic              err_q;
    logic              mis_q;

    logic              op_valid;
    logic [1:0]        size;
    logic [1:0]        off;
    logic              misaligned;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_rep;
    logic [31:0]       aligned;
    logic              timeout_hit;
    logic              timeout_abort;

    assign op_valid = is_load(mem_op) || is_store(mem_op);
    assign size     = op_size(mem_op);
    assign off      = addr[1:0];

    always_comb begin
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_rep  = wdata;
        case (size)
            SIZE_B: begin
                be_calc   = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                misaligned = off[0];
                be_calc    = 4'b0011 << off;
                wdata_rep  = {2{wdata[15:0]}};
            end
            default: begin
                misaligned = |off;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == LSU_IDLE) begin
            cnt_q <= '0;
        end else if ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The TIMEOUT-th cycle spent in REQ+WAIT is the last one.
    assign timeout_hit = ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    lsu_load_align u_align (
        .op     (op_q),
        .off    (addr_q[1:0]),
        .word   (rword_q),
        .result (aligned)
    );

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        bus_req       = 1'b0;
        done          = 1'b0;
        misalign_err  = 1'b0;
        access_err    = 1'b0;
        rdata_out     = 32'h0;
        timeout_abort = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (op_valid) begin
                    stall   = 1'b1;
                    state_d = misaligned ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (timeout_hit) begin
                    timeout_abort = 1'b1;
                    state_d       = LSU_DONE;
                end else if (bus_gnt) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    state_d = LSU_DONE;
                end else if (timeout_hit) begin
                    timeout_abort = 1'b1;
                    state_d       = LSU_DONE;
                end
            end
            LSU_DONE: begin
                done         = 1'b1;
                misalign_err = mis_q;
                access_err   = err_q;
                if (is_load(op_q) && !err_q && !mis_q) begin
                    rdata_out = aligned;
                end
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            op_q    <= MEM_NONE;
            addr_q  <= '0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rword_q <= 32'h0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == LSU_IDLE) && op_valid) begin
                op_q    <= mem_op;
                addr_q  <= addr;
                be_q    <= be_calc;
                wdata_q <= wdata_rep;
                mis_q   <= misaligned;
                err_q   <= 1'b0;
                rword_q <= 32'h0;
            end
            if ((state_q == LSU_WAIT) && bus_rvalid) begin
                rword_q <= bus_rdata;
                err_q   <= bus_err;
            end
            if (timeout_abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_we    = is_store(op_q);
    assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the core's decoded memory-op field and a wait-state data-memory bus with a request/grant/response handshake.
- Holds the PC through `stall` until the access completes.
- Generates byte enables and lane-replicated store data; aligns and sign/zero-extends load data.
- Flags misaligned addresses and bus errors.
- Sits beside the main decoder and replaces the combinational data-memory path.

Parameters:
- ADDR_W, 32, address width (bus_addr is word-aligned, bits [1:0] always 0)
- TIMEOUT, 255, max cycles in REQ+WAIT before forced abort (used only with watchdog)

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- mem_op  in  4  decoded op: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0110 LHU, 1001 SB, 1010 SH, 1111 SW; other codes treated as none
- addr  in  ADDR_W  effective address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC/regfile write-enable
- rdata_out  out  32  extended load result, valid when done=1
- done  out  1  one-cycle completion pulse
- misalign_err  out  1  pulse with done: misaligned access, no bus cycle issued
- access_err  out  1  pulse with done: bus_err or timeout
- bus_req  out  1  request
- bus_we  out  1  1=write
- bus_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/write-ack
- bus_rdata  in  32  read word
- bus_err  in  1  error, qualified by bus_rvalid

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (rst_n=0 at posedge): state=IDLE; bus_req=0, rdata_out=0, done=0, both errs=0; stall forced 0 while rst_n=0. Reset mid-access abandons it; a later stray rvalid is ignored.
- stall = (IDLE && valid op) || REQ || WAIT. It is combinational in IDLE so the instruction is held in its first cycle. stall=0 in DONE.
- IDLE, valid op:
  - If misaligned (H with addr[0]=1, W with addr[1:0]!=0): go to DONE with misalign_err=1; no bus_req.
  - Otherwise: latch op, addr, be, wdata; go to REQ.
- REQ:
  - bus_req=1; bus_we/addr/be/wdata held stable until bus_gnt.
  - On bus_gnt: bus_req deasserts next cycle; go to WAIT.
  - A bus_rvalid in the same cycle as gnt is illegal on this bus and is ignored.
- WAIT: on bus_rvalid, capture bus_rdata/bus_err and go to DONE. Stores also wait for rvalid (write ack).
- DONE:
  - done=1 for exactly one cycle; rdata_out valid; access_err = captured bus_err.
  - Next state IDLE. The core advances on this cycle, so the same instruction is never reissued.
- Minimum latency:
  - Aligned access, gnt and rvalid each one cycle late: 4 cycles IDLE→REQ→WAIT→DONE.
  - Misaligned access: 2 cycles.
- Byte enables, off = addr[1:0]:
  - B: be = 0001<<off.
  - H: be = 0011<<off.
  - W: be = 1111.
- Store data: SB replicates wdata[7:0] ×4; SH replicates wdata[15:0] ×2; SW passes through.
- Load data:
  - Byte lane off (LB/LBU) or half lane off[1] (LH/LHU) is selected from the captured word.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - rdata_out = 0 on misalign or error. Stores leave rdata_out = 0.
- bus_rvalid outside WAIT is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on IDLE→REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT: bus_req drops and the FSM goes to DONE with access_err=1.
  - Later rvalid for the aborted access is ignored in IDLE. If a new request is already in REQ, the stray response is the system's responsibility.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Shared package riscv_pkg:
  - mem_op encodings (MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW).
  - lsu_state_t enum.
  - Helper constants for is_load/is_store/size.
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension from {op, off, word}.

Test Plan:
- LW addr=0x100, gnt +1 cycle, rvalid +2, rdata=0xDEADBEEF → bus_be=1111, bus_addr=0x100, stall high 3 cycles, done with rdata_out=0xDEADBEEF.
- LB addr=0x103, rdata=0x80FF_FF_FF → be=1000, rdata_out=0xFFFFFF80; LBU same → 0x00000080.
- SH addr=0x102, wdata=0x1234ABCD → bus_we=1, be=1100, bus_wdata=0xABCDABCD; done on write ack; rdata_out=0.
- LW addr=0x101 → no bus_req ever; done+misalign_err after 2 cycles; LH addr=0x103 likewise.
- bus_gnt withheld 5 cycles → bus_req/addr/be stable all 5; then rvalid with bus_err=1 → done, access_err=1, rdata_out=0.
- rst_n low while in WAIT → IDLE next edge, bus_req=0, stall=0; rvalid after reset → ignored. With LSU_TIMEOUT_EN and TIMEOUT=8, no gnt → access_err at cycle 8.
